// File: rtl/byte_serializer_if.sv
// Pop-side link between the byte queue and its serializing drain stage.
// The serializer is the master: it requests pops and reads occupancy and data.
interface byte_serializer_if;
  logic       dequeue_out;
  logic [3:0] len_in;
  logic [7:0] data_in;

  modport master (
    output dequeue_out,
    input  len_in,
    input  data_in
  );

  modport slave (
    input  dequeue_out,
    output len_in,
    output data_in
  );
endinterface

// File: rtl/byte_serializer.sv
// Drains the byte queue and sends each byte as a start/8 data (LSB first)/[even parity]/stop
// frame on serial_out, counting completed frames.
module byte_serializer #(
  parameter int unsigned BIT_CYCLES = 4,
  parameter bit          PARITY_EN  = 1'b0
) (
  input  logic                      clk_10khz,
  input  logic                      reset,
  input  logic                      enable_in,
  byte_serializer_if.master         queue_if,
  output logic                      serial_out,
  output logic                      busy_out,
  output logic [7:0]                byte_count_out
);

  localparam int unsigned CntW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StPop, StCheck, StStart, StData, StParity, StStop
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            par_q, par_d;
  logic [3:0]      len_snap_q, len_snap_d;
  logic            deq_q, deq_d;
  logic            ser_q, ser_d;
  logic [7:0]      count_q, count_d;
  logic            bit_end;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    len_snap_d = len_snap_q;
    count_d    = count_q;
    bit_end    = (cnt_q == CntMax);

    if (state_q inside {StStart, StData, StParity, StStop}) begin
      cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (enable_in && (queue_if.len_in != 4'd0)) state_d = StPop;
      end
      StPop: begin
        len_snap_d = queue_if.len_in;
        state_d    = StCheck;
      end
      StCheck: begin
        // Enqueue wins a collision, so only a drop by exactly one proves the pop happened.
        if ((len_snap_q != 4'd0) && (queue_if.len_in == len_snap_q - 4'd1)) begin
          shreg_d = queue_if.data_in;
          par_d   = ^queue_if.data_in;
          cnt_d   = '0;
          state_d = StStart;
        end else begin
          state_d = StIdle;
        end
      end
      StStart: begin
        if (bit_end) begin
          idx_d   = 3'd0;
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = PARITY_EN ? StParity : StStop;
        end
      end
      StParity: begin
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) begin
          count_d = count_q + 8'd1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so derive them from the state being entered.
    deq_d = (state_d == StPop);
    case (state_d)
      StStart:  ser_d = 1'b0;
      StData:   ser_d = shreg_d[idx_d];
      StParity: ser_d = par_d;
      default:  ser_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_10khz or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= 3'd0;
      shreg_q    <= 8'd0;
      par_q      <= 1'b0;
      len_snap_q <= 4'd0;
      deq_q      <= 1'b0;
      ser_q      <= 1'b1;
      count_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      len_snap_q <= len_snap_d;
      deq_q      <= deq_d;
      ser_q      <= ser_d;
      count_q    <= count_d;
    end
  end

  assign queue_if.dequeue_out = deq_q;
  assign serial_out           = ser_q;
  assign busy_out             = (state_q != StIdle);
  assign byte_count_out       = count_q;

endmodule
